edge_event_monitor: RTL and testbench
=====================================

Name: edge_event_monitor

Overview:
- Parametrised, multi-channel edge detector. Successor to the single-bit, single-mode edge detect used across the CPLD.
- Per channel: input synchroniser, glitch filter, per-channel edge mode (off/rise/fall/both), one-cycle event pulse, and a sticky event flag with write-1-to-clear.
- Sits between raw board signals (PG, PRSNT, alert lines) and the sequencing/interrupt logic. It replaces ad-hoc per-signal edge detect plus debounce.

Parameters:
- CH, 8, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=1). All are reset to 0.
- FILT_CYCLES, 3, consecutive stable clocks required before the filtered level changes (>=1). A value of 1 means no filtering beyond one register.
- CNT_W, $clog2(FILT_CYCLES+1), filter counter width (derived; do not override).

Ports:
- iClk  in  1  system clock.
- iRst_n  in  1  asynchronous active-low reset.
- iSig  in  CH  raw asynchronous inputs, one per channel.
- iMode  in  2*CH  per-channel mode; bits [2i+1:2i] are for channel i: 00 off, 01 rising, 10 falling, 11 both.
- iClr  in  CH  sticky clear, one bit per channel. A high bit during a clock clears that channel's sticky flag.
- oLevel  out  CH  filtered, synchronised level.
- oPulse  out  CH  one-clock event pulse per channel.
- oSticky  out  CH  latched event flags.
- oAny  out  1  OR-reduction of oSticky.

Behaviour:
- Reset (asynchronous, iRst_n=0): all sync flops 0, filter counters 0, oLevel 0, oPulse 0, oSticky 0, oAny 0. Release is synchronous to iClk by the system reset bridge.
- Synchroniser: iSig[i] passes through SYNC_STAGES flops; the last stage is sync[i].
- Filter, per channel, every clock:
  - sync==oLevel: counter<=0.
  - sync!=oLevel and counter==FILT_CYCLES-1: oLevel<=sync, counter<=0.
  - Otherwise: counter<=counter+1.
  - Any sample where sync equals oLevel restarts the count, so a glitch shorter than FILT_CYCLES clocks never reaches oLevel.
  - The counter never exceeds FILT_CYCLES-1 and never wraps.
- Edge qualification, registered:
  - oPulse[i] is asserted for exactly one clock, the same cycle oLevel[i] takes its new value, when the mode allows that direction.
  - Rising = 0->1, allowed by mode 01 or 11. Falling = 1->0, allowed by mode 10 or 11. Mode 00 never pulses.
  - oLevel always tracks, regardless of mode.
- Latency: an input transition held stable reaches oLevel/oPulse SYNC_STAGES+FILT_CYCLES clock edges after the first edge that samples it. With defaults this is 5 edges.
- Mode is sampled on the clock edge on which the level changes. A mode change on that same edge takes effect immediately; there is no history.
- Sticky flags:
  - oSticky[i] is set on any cycle oPulse[i] is (being) asserted. It holds until cleared by iClr[i].
  - Simultaneous set and clear on the same edge: set wins, so the flag stays 1.
  - Clearing an already-clear flag has no effect.
- oAny is registered as the OR of the next-state sticky vector, so it is coincident with oSticky.
- Power-up: oLevel resets to 0. An input that is high from reset therefore produces a rising event after the latency above. This is intended: presence is reported at boot.
- Channels are fully independent. No cross-channel priority or arbitration.
- Reset asserted mid-filter or with a pending pulse: everything returns to reset values immediately. No pulse is emitted on reset release unless the input is high, which follows the power-up rule.

Test Plan:
- Reset, defaults, iSig=0x00, mode all 01; raise iSig[0] and hold -> oLevel[0]=1 and oPulse[0]=1 for exactly one clock, 5 edges after the first sampling edge; oSticky=0x01; oAny=1.
- Glitch: iSig[3]=1 for 2 clocks, then 0 (FILT_CYCLES=3) -> oLevel[3] stays 0, no pulse, sticky unchanged. Repeat with 3 clocks -> rising pulse.
- Modes: ch1 mode 10, ch2 mode 11, ch4 mode 00; toggle each 0->1->0 with long holds -> ch1 one pulse (falling), ch2 two pulses, ch4 zero pulses; oLevel tracks on all three.
- Sticky: after an event on ch5, assert iClr=0x20 -> oSticky[5]=0 next clock, oAny=0. Then assert iClr[5] on the same edge as a new ch5 pulse -> oSticky[5] remains 1.
- Async reset mid-filter: ch6 counter at 2, pull iRst_n low between clock edges -> all outputs 0 without a clock. Release with iSig[6]=1 -> rising pulse after 5 edges.
- Parameter sweep: CH=1, SYNC_STAGES=1, FILT_CYCLES=1 -> latency 2 edges, pulse width 1 clock. CH=16, FILT_CYCLES=10 -> 9-clock glitch rejected, 10-clock accepted.

Source files
------------

// File: rtl/edge_event_monitor.sv
// Multi-channel edge event monitor: sync, glitch filter,
// per-channel edge mode, one-cycle pulse and sticky W1C flags.
module edge_event_monitor #(
  parameter int CH          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int CNT_W       = $clog2(FILT_CYCLES + 1)
) (
  input  logic            iClk,
  input  logic            iRst_n,
  input  logic [CH-1:0]   iSig,
  input  logic [2*CH-1:0] iMode,
  input  logic [CH-1:0]   iClr,
  output logic [CH-1:0]   oLevel,
  output logic [CH-1:0]   oPulse,
  output logic [CH-1:0]   oSticky,
  output logic            oAny
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(FILT_CYCLES - 1);

  logic [CH-1:0]    sync_d [SYNC_STAGES];
  logic [CH-1:0]    sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_d  [CH];
  logic [CNT_W-1:0] cnt_q  [CH];
  logic [CH-1:0]    level_d, level_q;
  logic [CH-1:0]    pulse_d, pulse_q;
  logic [CH-1:0]    sticky_d, sticky_q;
  logic             any_d, any_q;
  logic [CH-1:0]    sync_w;

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain.
  always_comb begin
    sync_d[0] = iSig;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Filter, edge qualification and sticky next-state.
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_w[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = sync_w[i];
        cnt_d[i]   = '0;
        pulse_d[i] = sync_w[i] ? iMode[2*i]
                               : iMode[2*i+1];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    sticky_d = (sticky_q & ~iClr) | pulse_d;
    any_d    = |sticky_d;
  end

  // State registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q  <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      any_q    <= 1'b0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      any_q    <= any_d;
    end
  end

  assign oLevel  = level_q;
  assign oPulse  = pulse_q;
  assign oSticky = sticky_q;
  assign oAny    = any_q;

endmodule

// File: tb/tb_edge_event_monitor.sv
// Directed bench for edge_event_monitor: defaults,
// minimal (1/1/1) and wide (16 ch, 10-cycle filter).
module tb_edge_event_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sig0, clr0;
  logic [15:0] mode0;
  logic [7:0]  lvl0, pls0, stk0;
  logic        any0;

  logic        sig1, clr1;
  logic [1:0]  mode1;
  logic        lvl1, pls1, stk1, any1;

  logic [15:0] sig2, clr2;
  logic [31:0] mode2;
  logic [15:0] lvl2, pls2, stk2;
  logic        any2;

  int total = 0;
  int bad   = 0;
  int pc [8];
  int pc2   = 0;
  int base [8];
  int base2;

  always #5 clk = ~clk;

  edge_event_monitor u0 (
    .iClk(clk), .iRst_n(rst_n), .iSig(sig0),
    .iMode(mode0), .iClr(clr0), .oLevel(lvl0),
    .oPulse(pls0), .oSticky(stk0), .oAny(any0));

  edge_event_monitor #(
    .CH(1), .SYNC_STAGES(1), .FILT_CYCLES(1)
  ) u1 (
    .iClk(clk), .iRst_n(rst_n), .iSig(sig1),
    .iMode(mode1), .iClr(clr1), .oLevel(lvl1),
    .oPulse(pls1), .oSticky(stk1), .oAny(any1));

  edge_event_monitor #(
    .CH(16), .SYNC_STAGES(2), .FILT_CYCLES(10)
  ) u2 (
    .iClk(clk), .iRst_n(rst_n), .iSig(sig2),
    .iMode(mode2), .iClr(clr2), .oLevel(lvl2),
    .oPulse(pls2), .oSticky(stk2), .oAny(any2));

  initial for (int i = 0; i < 8; i++) pc[i] = 0;

  // Count pulse cycles mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 8; i++) pc[i] += int'(pls0[i]);
      pc2 += int'(pls2[15]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 8; i++) base[i] = pc[i];
    base2 = pc2;
  endtask

  initial begin
    rst_n = 1'b0;
    sig0 = '0; clr0 = '0; mode0 = 16'h5555;
    sig1 = 1'b0; clr1 = 1'b0; mode1 = 2'b01;
    sig2 = '0; clr2 = '0; mode2 = 32'h5555_5555;
    #12;
    chk("rst_level", 32'(lvl0), 32'h0);
    chk("rst_pulse", 32'(pls0), 32'h0);
    chk("rst_sticky", 32'(stk0), 32'h0);
    chk("rst_any", 32'(any0), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(3);

    // Rise on ch0: 5-edge latency, 1-cycle pulse.
    sig0[0] = 1'b1;
    tick(4);
    chk("ch0_lat4_level", 32'(lvl0[0]), 32'h0);
    tick(1);
    chk("ch0_lat5_level", 32'(lvl0[0]), 32'h1);
    chk("ch0_lat5_pulse", 32'(pls0), 32'h01);
    chk("ch0_sticky", 32'(stk0), 32'h01);
    chk("ch0_any", 32'(any0), 32'h1);
    tick(1);
    chk("ch0_pulse_end", 32'(pls0), 32'h0);

    // ch3 glitch of 2 clocks is rejected.
    snap();
    sig0[3] = 1'b1;
    tick(2);
    sig0[3] = 1'b0;
    tick(8);
    chk("glitch2_level", 32'(lvl0[3]), 32'h0);
    chk("glitch2_pulses", pc[3] - base[3], 0);
    chk("glitch2_sticky", 32'(stk0), 32'h01);

    // 3 clocks is accepted.
    sig0[3] = 1'b1;
    tick(3);
    sig0[3] = 1'b0;
    tick(10);
    chk("hold3_pulses", pc[3] - base[3], 1);
    chk("hold3_sticky", 32'(stk0), 32'h09);

    // Modes: ch1 fall, ch2 both, ch4 off.
    mode0 = 16'h5479;
    snap();
    sig0 = sig0 | 8'h16;
    tick(8);
    chk("mode_lvl_hi", 32'(lvl0 & 8'h16), 32'h16);
    sig0 = sig0 & ~8'h16;
    tick(8);
    chk("mode_lvl_lo", 32'(lvl0 & 8'h16), 32'h00);
    chk("mode_ch1_fall", pc[1] - base[1], 1);
    chk("mode_ch2_both", pc[2] - base[2], 2);
    chk("mode_ch4_off", pc[4] - base[4], 0);
    chk("mode_sticky", 32'(stk0), 32'h0F);
    mode0 = 16'h5555;

    // Sticky clear on ch5.
    clr0 = 8'hFF;
    tick(1);
    clr0 = 8'h00;
    chk("clr_all_any", 32'(any0), 32'h0);
    sig0[5] = 1'b1;
    tick(8);
    chk("ch5_set", 32'(stk0), 32'h20);
    clr0 = 8'h20;
    tick(1);
    clr0 = 8'h00;
    chk("ch5_clr", 32'(stk0), 32'h00);
    chk("ch5_clr_any", 32'(any0), 32'h0);
    clr0 = 8'h20;
    tick(1);
    clr0 = 8'h00;
    chk("clr_idle", 32'(stk0), 32'h00);

    // Set and clear on the same edge: set wins.
    sig0[5] = 1'b0;
    tick(8);
    sig0[5] = 1'b1;
    tick(4);
    clr0 = 8'h20;
    tick(1);
    clr0 = 8'h00;
    chk("setclr_pulse", 32'(pls0[5]), 32'h1);
    chk("setclr_sticky", 32'(stk0), 32'h20);
    chk("setclr_any", 32'(any0), 32'h1);

    // Async reset with ch6 counter at 2.
    sig0[6] = 1'b1;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(lvl0), 32'h0);
    chk("arst_pulse", 32'(pls0), 32'h0);
    chk("arst_sticky", 32'(stk0), 32'h0);
    chk("arst_any", 32'(any0), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(4);
    chk("rel_lat4", 32'(lvl0[6]), 32'h0);
    tick(1);
    chk("rel_lat5_pulse", 32'(pls0[6]), 32'h1);
    chk("rel_lat5_level", 32'(lvl0[6]), 32'h1);

    // Minimal config: 2-edge latency.
    sig1 = 1'b1;
    tick(1);
    chk("min_lat1", 32'(lvl1), 32'h0);
    tick(1);
    chk("min_lat2_level", 32'(lvl1), 32'h1);
    chk("min_lat2_pulse", 32'(pls1), 32'h1);
    tick(1);
    chk("min_pulse_end", 32'(pls1), 32'h0);
    chk("min_sticky", 32'(stk1), 32'h1);

    // Wide config: 9 rejected, 10 accepted.
    snap();
    sig2[15] = 1'b1;
    tick(9);
    sig2[15] = 1'b0;
    tick(20);
    chk("wide_g9_level", 32'(lvl2), 32'h0);
    chk("wide_g9_pulses", pc2 - base2, 0);
    sig2[15] = 1'b1;
    tick(10);
    sig2[15] = 1'b0;
    tick(2);
    chk("wide_h10_level", 32'(lvl2), 32'h8000);
    chk("wide_h10_sticky", 32'(stk2), 32'h8000);
    tick(20);
    chk("wide_h10_pulses", pc2 - base2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
